mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-ported unified memory between fetch (IF) and data-memory (DM) requesters.
//   Sits between the pipeline's instr/data access points and the backing memory.
//   Emits if_stall/dm_stall, which pipeline_control ORs into F_stall/D_stall/E_bubble.
//   FSM-sequenced, one outstanding memory transaction at a time.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   STARVE_MAX  4   consecutive contested DM grants before IF wins; legal 1..15
// PORTS
//   clk        in   1       sole clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   if_req     in   1       fetch read request; held with if_addr stable until if_ack
//   if_addr    in   ADDR_W  fetch address
//   if_rdata   out  DATA_W  fetch data, valid while if_ack=1
//   if_ack     out  1       one-cycle completion pulse
//   if_stall   out  1       if_req & ~if_ack
//   dm_req     in   1       data request; dm_we/dm_addr/dm_wdata stable until dm_ack
//   dm_we      in   1       1=write, 0=read
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  write data
//   dm_rdata   out  DATA_W  read data, valid while dm_ack=1
//   dm_ack     out  1       one-cycle completion pulse
//   dm_stall   out  1       dm_req & ~dm_ack
//   mem_req    out  1       held high until mem_ack
//   mem_we     out  1       latched write enable
//   mem_addr   out  ADDR_W  latched address
//   mem_wdata  out  DATA_W  latched write data
//   mem_ack    in   1       transaction done; mem_rdata valid this cycle
//   mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//   - Reset values: state=IDLE; mem_req/mem_we/if_ack/dm_ack=0; mem_addr/mem_wdata/if_rdata/dm_rdata=0; starve_cnt=0.
//   - States: IDLE -> BUSY_IF | BUSY_DM -> RESP_IF | RESP_DM -> IDLE.
//   - IDLE: winner's addr/we/wdata latched into mem_* regs; mem_req=1 from next cycle. IF always has mem_we=0.
//   - BUSY_x: mem_req held, mem_* stable. mem_ack -> capture mem_rdata into x_rdata, go RESP_x.
//   - RESP_x: x_ack=1 for exactly this cycle; mem_req=0; next state IDLE.
//   - Latency: req seen at cycle 0 -> mem_req from cycle 1 -> mem_ack at cycle 1+k (k>=0) -> x_ack at cycle 2+k.
//   - Throughput: one transaction per 3+k cycles. Requester held high after its ack is re-arbitrated in IDLE as a new request.
//   - Priority: DM over IF (DM belongs to the older instruction).
//     - Exception: starve_cnt==STARVE_MAX with both requesting -> IF wins.
//     - starve_cnt increments on each DM grant while if_req=1; clears on IF grant or any IDLE cycle with if_req=0.
//     - starve_cnt saturates at STARVE_MAX.
//   - Simultaneous if_req & dm_req in IDLE: apply the priority rule above, same cycle.
//   - mem_ack outside BUSY_x: ignored; no state or output change.
//   - Requester dropping req mid-transaction is a protocol violation; the transaction still completes and the ack is still pulsed.
//   - rst mid-transaction: immediate return to reset values; the outstanding memory access is abandoned (memory model shares rst).
//   - Stall outputs are combinational from registered acks and raw reqs; no path from mem_* to stalls.
// CONFIGURATION
//   MEM_ARB_PERF_EN defined:
//     - Adds outputs perf_if_grants[31:0], perf_dm_grants[31:0], perf_conflict_cyc[31:0].
//     - Conflict cycle = IDLE cycle with both reqs high, or a BUSY/RESP cycle with the other req high.
//     - All three are saturating counters, cleared by rst.
//   Not defined: those ports and counters do not exist; arbitration is identical either way.
// STRUCTURE
//   - mem_arb_defs.vh (shared include): state encodings ST_IDLE, ST_BUSY_IF, ST_BUSY_DM, ST_RESP_IF, ST_RESP_DM (3 bits).
//   - Starve counter width: 4.
//   - One sub-module, mem_arb_perf_cnt: the three saturating counters, instantiated only under MEM_ARB_PERF_EN.
// TESTING  (memory model acks k=2 cycles after mem_req rises unless stated)
//   1. Single IF read, if_addr=0x40, mem_rdata=0x2008000A -> mem_req cycles 1..3, if_ack only at cycle 4 with if_rdata=0x2008000A; if_stall=1 at cycles 0..3.
//   2. DM write, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until mem_ack; dm_ack single pulse.
//   3. if_req and dm_req both rise at cycle 0 -> DM served first, IF granted in the IDLE after RESP_DM; no overlap of mem_req.
//   4. STARVE_MAX=4, dm_req held high with if_req high -> exactly 4 DM grants, 5th grant to IF, then starve_cnt=0 and DM resumes.
//   5. rst asserted while in BUSY_DM (k=5) -> next cycle mem_req=0, dm_ack=0, state IDLE; late mem_ack ignored.
//   6. k=0 (mem_ack same cycle as first mem_req) -> ack at cycle 2. With MEM_ARB_PERF_EN, after tests 3-4: perf_if_grants/perf_dm_grants match granted counts.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the unified-memory arbiter:
//     - state_t     : arbiter FSM states (3-bit encoding, also exported on the
//                     top-level debug port so checkers can bind to it)
//     - STARVE_W    : width of the IF starvation counter
//     - PERF_W      : width of the optional performance counters
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_DM = 3'd2,
        ST_RESP_IF = 3'd3,
        ST_RESP_DM = 3'd4
    } state_t;

    localparam int STARVE_W = 4;
    localparam int PERF_W   = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the three request/response channels around the arbiter:
//     IF  channel : if_req, if_addr -> if_rdata, if_ack, if_stall
//     DM  channel : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack, dm_stall
//     MEM channel : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (pipeline requesters + backing memory)
//
//   Handshake semantics (all channels):
//     A requester raises req and holds req and its payload stable until it
//     sees a one-cycle ack pulse; data returned with an ack is valid only in
//     that ack cycle. Keeping req high in the ack cycle (or after) is a new
//     request. On the memory side the arbiter holds mem_req and the mem_*
//     payload stable until mem_ack; mem_rdata is valid in the mem_ack cycle.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_perf_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_perf_cnt
//   Three saturating event counters for the arbiter; exists only when the
//   build defines MEM_ARB_PERF_EN.
//   Ports:
//     clk, rst                : clock, synchronous active-high clear
//     if_grant_i, dm_grant_i  : one-cycle grant strobes
//     conflict_i              : cycle in which the other requester had to wait
//     perf_*_o                : counter values
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf_cnt
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_grant_i,
    input  logic              dm_grant_i,
    input  logic              conflict_i,
    output logic [PERF_W-1:0] perf_if_grants_o,
    output logic [PERF_W-1:0] perf_dm_grants_o,
    output logic [PERF_W-1:0] perf_conflict_cyc_o
);
    logic [PERF_W-1:0] if_cnt_q, dm_cnt_q, cf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_cnt_q <= '0;
            dm_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            // All-ones is the saturation point.
            if (if_grant_i && !(&if_cnt_q)) if_cnt_q <= if_cnt_q + 1'b1;
            if (dm_grant_i && !(&dm_cnt_q)) dm_cnt_q <= dm_cnt_q + 1'b1;
            if (conflict_i && !(&cf_cnt_q)) cf_cnt_q <= cf_cnt_q + 1'b1;
        end
    end

    assign perf_if_grants_o    = if_cnt_q;
    assign perf_dm_grants_o    = dm_cnt_q;
    assign perf_conflict_cyc_o = cf_cnt_q;
endmodule
`endif

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and data
//   memory (DM). One memory transaction outstanding at a time:
//     IDLE -> BUSY_IF | BUSY_DM -> RESP_IF | RESP_DM -> IDLE
//   DM has priority (older instruction) unless IF has lost STARVE_MAX
//   contested arbitrations in a row, in which case IF wins once.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     bus           : mem_arbiter_if.slave (IF, DM and memory channels)
//     state_o       : FSM state (debug)
//     starve_cnt_o  : IF starvation counter (debug)
//     perf_*        : grant / conflict counters, only with MEM_ARB_PERF_EN
//   Optional feature macro: MEM_ARB_PERF_EN
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_if.slave        bus,
    output state_t              state_o,
    output logic [STARVE_W-1:0] starve_cnt_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]   perf_if_grants,
    output logic [PERF_W-1:0]   perf_dm_grants,
    output logic [PERF_W-1:0]   perf_conflict_cyc
`endif
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t              state_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ack_q, dm_ack_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic [STARVE_W-1:0] starve_q;

    logic starve_hit, grant_dm, grant_if;

    // Arbitration decision; only acted upon in IDLE.
    always_comb begin
        starve_hit = (starve_q == STARVE_LIM);
        grant_dm   = bus.dm_req && !(bus.if_req && starve_hit);
        grant_if   = bus.if_req && !grant_dm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!bus.if_req) starve_q <= '0;
                    if (grant_dm) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        state_q     <= ST_BUSY_DM;
                        // A contested DM grant implies starve_hit is false,
                        // so the increment can never pass STARVE_LIM.
                        if (bus.if_req) starve_q <= starve_q + 1'b1;
                    end else if (grant_if) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        state_q    <= ST_BUSY_IF;
                        starve_q   <= '0;
                    end
                end
                ST_BUSY_IF: begin
                    if (bus.mem_ack) begin
                        if_rdata_q <= bus.mem_rdata;
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        state_q    <= ST_RESP_IF;
                    end
                end
                ST_BUSY_DM: begin
                    if (bus.mem_ack) begin
                        dm_rdata_q <= bus.mem_rdata;
                        mem_req_q  <= 1'b0;
                        dm_ack_q   <= 1'b1;
                        state_q    <= ST_RESP_DM;
                    end
                end
                ST_RESP_IF, ST_RESP_DM: state_q <= ST_IDLE;
                default:                state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    // Stalls depend only on raw requests and registered acks.
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;

    assign state_o      = state_q;
    assign starve_cnt_o = starve_q;

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    always_comb begin
        conflict = 1'b0;
        case (state_q)
            ST_IDLE:                conflict = bus.if_req && bus.dm_req;
            ST_BUSY_IF, ST_RESP_IF: conflict = bus.dm_req;
            ST_BUSY_DM, ST_RESP_DM: conflict = bus.if_req;
            default:                conflict = 1'b0;
        endcase
    end

    mem_arb_perf_cnt u_perf (
        .clk                 (clk),
        .rst                 (rst),
        .if_grant_i          ((state_q == ST_IDLE) && grant_if),
        .dm_grant_i          ((state_q == ST_IDLE) && grant_dm),
        .conflict_i          (conflict),
        .perf_if_grants_o    (perf_if_grants),
        .perf_dm_grants_o    (perf_dm_grants),
        .perf_conflict_cyc_o (perf_conflict_cyc)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int SMAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  state_t     state_o;
  logic [3:0] starve_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if, perf_dm, perf_cf;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .state_o      (state_o),
    .starve_cnt_o (starve_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_grants    (perf_if),
    .perf_dm_grants    (perf_dm),
    .perf_conflict_cyc (perf_cf)
`endif
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // requester levels applied for the coming clock edge
  logic        v_rst = 1'b1, v_if_req = 1'b0, v_dm_req = 1'b0, v_dm_we = 1'b0;
  logic [31:0] v_if_addr = '0, v_dm_addr = '0, v_dm_wdata = '0;
  int          k_mode = 2;      // memory latency k; negative = random 0..3
  int          stray_mode = 0;  // 0 none, 1 random, 2 always (outside busy window)

  // reference model: one transaction, described by its timestamps
  bit          t_on = 0, t_dm = 0, t_we = 0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  int          t_g = 0, t_mack = 0, t_ack = 0, free_at = 0, starve = 0;
  bit          e_if_ack, e_dm_ack;
  int          n_if_gr = 0, n_dm_gr = 0, n_conf = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];
  int          ack_log[$];   // 0 = IF ack, 1 = DM ack
  logic [31:0] mem_store[logic [31:0]];  // what the memory model serves
  logic [31:0] ref_mem[logic [31:0]];    // what the requesters should see

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction
  function automatic logic [31:0] store_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver / scoreboard tasks ----------------
  // Start of a cycle: sample DUT outputs at the falling edge and compare.
  task automatic cycle_begin();
    bit busy;
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    busy     = t_on && (cyc > t_g) && (cyc <= t_mack);
    e_if_ack = t_on && (cyc == t_ack) && !t_dm;
    e_dm_ack = t_on && (cyc == t_ack) && t_dm;
    chk("mem_req", 32'(bus.mem_req), 32'(busy));
    if (busy) begin
      chk("mem_we", 32'(bus.mem_we), 32'(t_we));
      chk("mem_addr", bus.mem_addr, t_addr);
      if (t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
    end
    chk("if_ack", 32'(bus.if_ack), 32'(e_if_ack));
    chk("dm_ack", 32'(bus.dm_ack), 32'(e_dm_ack));
    chk("if_stall", 32'(bus.if_stall), 32'(v_if_req & ~e_if_ack));
    chk("dm_stall", 32'(bus.dm_stall), 32'(v_dm_req & ~e_dm_ack));
    if (e_if_ack) begin
      ack_log.push_back(0);
      e = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'hFFFF_FFFF;
      chk("if_rdata", bus.if_rdata, e);
    end
    if (e_dm_ack) begin
      ack_log.push_back(1);
      if (!t_we) begin
        e = (dm_exp_q.size() > 0) ? dm_exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("dm_rdata", bus.dm_rdata, e);
      end
    end
  endtask

  // End of a cycle: apply requester levels, run the memory model, and let the
  // reference model arbitrate if memory is free in this cycle.
  task automatic cycle_end();
    bit          m;
    logic [31:0] md;
    int          k;
    rst          = v_rst;
    bus.if_req   = v_if_req;
    bus.if_addr  = v_if_addr;
    bus.dm_req   = v_dm_req;
    bus.dm_we    = v_dm_we;
    bus.dm_addr  = v_dm_addr;
    bus.dm_wdata = v_dm_wdata;
    m  = 1'b0;
    md = $urandom;
    if (!v_rst) begin
      if (t_on && cyc == t_mack) begin
        m  = 1'b1;
        md = store_rd(bus.mem_addr);
        if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
      end else if (!(t_on && cyc > t_g && cyc <= t_mack)) begin
        if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) m = 1'b1;
      end
    end
    bus.mem_ack   = m;
    bus.mem_rdata = md;

    if (v_rst) begin
      t_on = 0; free_at = cyc + 1; starve = 0;
      if_exp_q.delete(); dm_exp_q.delete();
      n_if_gr = 0; n_dm_gr = 0; n_conf = 0;
    end else if (cyc >= free_at) begin
      if (v_if_req && v_dm_req) n_conf++;
      if (!v_if_req) starve = 0;
      if (v_if_req || v_dm_req) begin
        t_dm = v_dm_req && !(v_if_req && starve == SMAX);
        if (t_dm) begin
          starve = v_if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
          n_dm_gr++;
          t_we = v_dm_we; t_addr = v_dm_addr; t_wdata = v_dm_wdata;
        end else begin
          starve = 0;
          n_if_gr++;
          t_we = 0; t_addr = v_if_addr; t_wdata = '0;
        end
        k      = (k_mode < 0) ? $urandom_range(0, 3) : k_mode;
        t_on   = 1;
        t_g    = cyc;
        t_mack = cyc + 1 + k;
        t_ack  = cyc + 2 + k;
        free_at = cyc + 3 + k;
        if (t_we)      ref_mem[t_addr] = t_wdata;
        else if (t_dm) dm_exp_q.push_back(ref_rd(t_addr));
        else           if_exp_q.push_back(ref_rd(t_addr));
      end
    end else if (t_on) begin
      if (t_dm ? v_if_req : v_dm_req) n_conf++;
    end
  endtask

  // Runs cycles until the chosen ack; leaves the caller inside that cycle.
  task automatic run_until_ack(input bit want_dm, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) cycle_end();
      cycle_begin();
      if ((want_dm && e_dm_ack) || (!want_dm && e_if_ack)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_begin();
      cycle_end();
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_perf_if"}, perf_if, 32'(n_if_gr));
    chk({tag, "_perf_dm"}, perf_dm, 32'(n_dm_gr));
    chk({tag, "_perf_cf"}, perf_cf, 32'(n_conf));
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, at;
    int pat[6];
    bit done;
    pat = '{1, 1, 1, 1, 0, 1};
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    mem_store[32'h40] = 32'h2008000A;
    ref_mem[32'h40]   = 32'h2008000A;

    // reset
    idle_cycles(3);
    cycle_begin();
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_starve", 32'(starve_o), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    v_rst = 0;
    cycle_end();
    idle_cycles(2);

    // T1: single IF read, k=2
    k_mode = 2;
    cycle_begin();
    v_if_req = 1; v_if_addr = 32'h40;
    cycle_end();
    c0 = cyc;
    #1 chk("t1_if_stall_c0", 32'(bus.if_stall), 32'd1);
    run_until_ack(0, 20, at);
    chk("t1_latency", 32'(at - c0), 32'd4);
    chk("t1_if_rdata", bus.if_rdata, 32'h2008000A);
    v_if_req = 0;
    cycle_end();
    idle_cycles(2);

    // T2: DM write
    cycle_begin();
    v_dm_req = 1; v_dm_we = 1; v_dm_addr = 32'h100; v_dm_wdata = 32'hDEADBEEF;
    cycle_end();
    c0 = cyc;
    run_until_ack(1, 20, at);
    chk("t2_latency", 32'(at - c0), 32'd4);
    v_dm_req = 0; v_dm_we = 0;
    cycle_end();
    chk("t2_mem_written", store_rd(32'h100), 32'hDEADBEEF);
    idle_cycles(2);

    // T3: simultaneous requests, DM first, then IF
    cycle_begin();
    ack_log.delete();
    v_dm_req = 1; v_dm_we = 0; v_dm_addr = 32'h100;
    v_if_req = 1; v_if_addr = 32'h44;
    cycle_end();
    c0 = cyc;
    run_until_ack(1, 20, at);
    chk("t3_dm_latency", 32'(at - c0), 32'd4);
    chk("t3_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);
    v_dm_req = 0;
    cycle_end();
    run_until_ack(0, 20, at);
    chk("t3_if_latency", 32'(at - c0), 32'd9);
    v_if_req = 0;
    cycle_end();
    chk("t3_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      chk("t3_first_dm", 32'(ack_log[0]), 32'd1);
      chk("t3_second_if", 32'(ack_log[1]), 32'd0);
    end
    idle_cycles(2);

    // T4: starvation limit with both requests held
    cycle_begin();
    ack_log.delete();
    v_dm_req = 1; v_dm_we = 0; v_dm_addr = 32'h104;
    v_if_req = 1; v_if_addr = 32'h48;
    cycle_end();
    done = 0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) cycle_end();
      cycle_begin();
      if (e_if_ack) chk("t4_starve_cleared", 32'(starve_o), 32'd0);
      if (ack_log.size() >= 6) begin done = 1; break; end
    end
    chk("t4_six_acks", 32'(done), 32'd1);
    for (int i = 0; i < 6; i++)
      if (i < ack_log.size()) chk($sformatf("t4_grant%0d", i), 32'(ack_log[i]), 32'(pat[i]));
    v_dm_req = 0; v_if_req = 0;
    cycle_end();
    idle_cycles(8);
`ifdef MEM_ARB_PERF_EN
    cycle_begin();
    chk_perf("t4");
    cycle_end();
`endif

    // T5: reset while BUSY_DM with k=5, then stray mem_ack in IDLE
    k_mode = 5;
    cycle_begin();
    v_dm_req = 1; v_dm_we = 0; v_dm_addr = 32'h108;
    cycle_end();
    idle_cycles(1);
    cycle_begin();
    chk("t5_busy_dm", 32'(state_o), 32'(ST_BUSY_DM));
    v_rst = 1; v_dm_req = 0;
    cycle_end();
    cycle_begin();
    chk("t5_rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("t5_rst_dm_rdata", bus.dm_rdata, 32'd0);
    v_rst = 0; stray_mode = 2;
    cycle_end();
    for (int i = 0; i < 3; i++) begin
      cycle_begin();
      chk("t5_stray_idle", 32'(state_o), 32'(ST_IDLE));
      cycle_end();
    end
    stray_mode = 0;
    idle_cycles(1);

    // T6: zero-latency memory
    k_mode = 0;
    cycle_begin();
    v_if_req = 1; v_if_addr = 32'h4C;
    cycle_end();
    c0 = cyc;
    run_until_ack(0, 20, at);
    chk("t6_latency", 32'(at - c0), 32'd2);
    v_if_req = 0;
    cycle_end();
    idle_cycles(2);

    // Random traffic with random latency and stray memory acks
    k_mode = -1; stray_mode = 1;
    for (int i = 0; i < 600; i++) begin
      cycle_begin();
      if (e_if_ack ? ($urandom_range(0, 1) == 1) : (!v_if_req && $urandom_range(0, 2) == 0)) begin
        v_if_req = 1; v_if_addr = 32'h40 + {$urandom_range(0, 15), 2'b00};
      end else if (e_if_ack) v_if_req = 0;
      if (e_dm_ack ? ($urandom_range(0, 1) == 1) : (!v_dm_req && $urandom_range(0, 2) == 0)) begin
        v_dm_req = 1; v_dm_we = 1'($urandom_range(0, 1));
        v_dm_addr = 32'h40 + {$urandom_range(0, 15), 2'b00}; v_dm_wdata = $urandom;
      end else if (e_dm_ack) v_dm_req = 0;
      cycle_end();
    end
    for (int i = 0; i < 40; i++) begin
      cycle_begin();
      if (e_if_ack) v_if_req = 0;
      if (e_dm_ack) v_dm_req = 0;
      cycle_end();
    end
    stray_mode = 0;
    cycle_begin();
    chk("rand_if_drained", 32'(if_exp_q.size()), 32'd0);
    chk("rand_dm_drained", 32'(dm_exp_q.size()), 32'd0);
    chk("rand_end_idle", 32'(state_o), 32'(ST_IDLE));
`ifdef MEM_ARB_PERF_EN
    chk_perf("end");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
